// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT datapath and its downstream consumers.
package fft_pkg;

    localparam int unsigned FFT_N = 3;
    localparam int unsigned FFT_W = 16;

    typedef logic signed [FFT_W-1:0] fpt;
    typedef struct packed {
        fpt re;
        fpt im;
    } cpx_t;
    typedef logic [2*FFT_W-1:0] pow_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } pd_state_t;

endpackage

// File: rtl/fft_pow_pipe.sv
// Two-stage bin power pipeline: S1 squares re/im, S2 sums; index and frame tag ride along.
module fft_pow_pipe
    import fft_pkg::*;
#(
    parameter int unsigned N = FFT_N,
    parameter int unsigned W = FFT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic signed [W-1:0]  i_re,
    input  logic signed [W-1:0]  i_im,
    input  logic [N-1:0]         i_idx,
    input  logic                 i_tag,
    output logic                 o_valid,
    output logic [2*W-1:0]       o_pow,
    output logic [N-1:0]         o_idx,
    output logic                 o_tag
);

    logic signed [2*W-1:0] w_re_x;
    logic signed [2*W-1:0] w_im_x;
    logic signed [2*W-1:0] w_rr;
    logic signed [2*W-1:0] w_ii;
    logic [2*W-1:0]        w_sum;

    logic signed [2*W-1:0] r_s1_rr;
    logic signed [2*W-1:0] r_s1_ii;
    logic                  r_s1_valid;
    logic [N-1:0]          r_s1_idx;
    logic                  r_s1_tag;

    logic                  r_s2_valid;
    logic [2*W-1:0]        r_s2_pow;
    logic [N-1:0]          r_s2_idx;
    logic                  r_s2_tag;

    // Sign-extend before multiplying so the full 2W-bit square is kept.
    assign w_re_x = (2*W)'(i_re);
    assign w_im_x = (2*W)'(i_im);
    assign w_rr   = w_re_x * w_re_x;
    assign w_ii   = w_im_x * w_im_x;
    assign w_sum  = $unsigned(r_s1_rr) + $unsigned(r_s1_ii);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rr    <= '0;
            r_s1_ii    <= '0;
            r_s1_idx   <= '0;
            r_s1_tag   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_pow   <= '0;
            r_s2_idx   <= '0;
            r_s2_tag   <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_rr    <= w_rr;
            r_s1_ii    <= w_ii;
            r_s1_idx   <= i_idx;
            r_s1_tag   <= i_tag;
            r_s2_valid <= r_s1_valid;
            r_s2_pow   <= w_sum;
            r_s2_idx   <= r_s1_idx;
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_pow   = r_s2_pow;
    assign o_idx   = r_s2_idx;
    assign o_tag   = r_s2_tag;

endmodule

// File: rtl/fft_peak_detect.sv
// Peak-power bin finder over the non-redundant half of a natural-order FFT frame,
// one {index, power} result per frame on a valid/ready port.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int unsigned N       = FFT_N,
    parameter int unsigned W       = FFT_W,
    parameter bit          SKIP_DC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic [1:0][W-1:0]    in_bin,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N-1:0]         res_idx,
    output logic [2*W-1:0]       res_pow,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam logic [N-1:0] LAST_IDX = '1;
    localparam logic [N-1:0] HALF_IDX = N'(2**(N-1));
    localparam logic [N-1:0] INIT_IDX = N'(SKIP_DC);

    pd_state_t        r_state;
    pd_state_t        w_state_nxt;
    logic [N-1:0]     r_cnt;
    logic [N-1:0]     w_cnt_nxt;
    logic [N-1:0]     w_bin_idx;
    logic             w_accept;
    logic             w_new_frame;
    logic             w_restart;
    logic             r_tag;
    logic             w_tag_in;

    logic             w_s2_valid;
    logic [2*W-1:0]   w_s2_pow;
    logic [N-1:0]     w_s2_idx;
    logic             w_s2_tag;

    logic             r_cur_tag;
    logic [2*W-1:0]   r_max_pow;
    logic [N-1:0]     r_max_idx;
    logic             w_s2_first;
    logic             w_tag_ok;
    logic             w_in_win;
    logic [2*W-1:0]   w_base_pow;
    logic [N-1:0]     w_base_idx;
    logic             w_take;
    logic [2*W-1:0]   w_cand_pow;
    logic [N-1:0]     w_cand_idx;
    logic             w_s3_fire;
    logic             w_load;

    logic             r_res_valid;
    logic [N-1:0]     r_res_idx;
    logic [2*W-1:0]   r_res_pow;
    logic             r_overrun;
    logic             r_frame_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bin_idx   = r_cnt;
        w_accept    = 1'b0;
        w_new_frame = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && in_first) begin
                    w_accept    = 1'b1;
                    w_new_frame = 1'b1;
                    w_bin_idx   = '0;
                    w_cnt_nxt   = N'(1);
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (in_first) begin
                        w_new_frame = 1'b1;
                        w_restart   = 1'b1;
                        w_bin_idx   = '0;
                        w_cnt_nxt   = N'(1);
                    end else begin
                        w_cnt_nxt = r_cnt + N'(1);
                        if (r_cnt == LAST_IDX) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_tag_in = w_new_frame ? ~r_tag : r_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tag       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tag   <= w_tag_in;
            if (w_restart) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    fft_pow_pipe #(
        .N (N),
        .W (W)
    ) u_pow_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_accept),
        .i_re    ($signed(in_bin[1])),
        .i_im    ($signed(in_bin[0])),
        .i_idx   (w_bin_idx),
        .i_tag   (w_tag_in),
        .o_valid (w_s2_valid),
        .o_pow   (w_s2_pow),
        .o_idx   (w_s2_idx),
        .o_tag   (w_s2_tag)
    );

    // The running max is re-seeded when bin 0 of a frame reaches S3, so a restarted
    // frame's leftover bins (always ahead of the new bin 0) never survive into its result.
    assign w_s2_first = (w_s2_idx == '0);
    assign w_tag_ok   = w_s2_first || (w_s2_tag == r_cur_tag);
    assign w_in_win   = (w_s2_idx <= HALF_IDX) && !(SKIP_DC && w_s2_first);
    assign w_base_pow = w_s2_first ? '0 : r_max_pow;
    assign w_base_idx = w_s2_first ? INIT_IDX : r_max_idx;
    assign w_take     = w_in_win && (w_s2_pow > w_base_pow);
    assign w_cand_pow = w_take ? w_s2_pow : w_base_pow;
    assign w_cand_idx = w_take ? w_s2_idx : w_base_idx;
    assign w_s3_fire  = w_s2_valid && w_tag_ok;
    assign w_load     = w_s3_fire && (w_s2_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_tag <= 1'b0;
            r_max_pow <= '0;
            r_max_idx <= INIT_IDX;
        end else if (w_s3_fire) begin
            r_cur_tag <= w_s2_tag;
            if (w_load) begin
                r_max_pow <= '0;
                r_max_idx <= INIT_IDX;
            end else begin
                r_max_pow <= w_cand_pow;
                r_max_idx <= w_cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_pow   <= '0;
            r_overrun   <= 1'b0;
        end else if (w_load) begin
            r_res_valid <= 1'b1;
            r_res_idx   <= w_cand_idx;
            r_res_pow   <= w_cand_pow;
            if (r_res_valid && !res_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_pow   = r_res_pow;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect (N=3, W=16, SKIP_DC=1).
module tb_fft_peak_detect;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_first;
    logic [1:0][15:0]  in_bin;
    logic              res_valid;
    logic              res_ready;
    logic [2:0]        res_idx;
    logic [31:0]       res_pow;
    logic              overrun;
    logic              frame_err;

    int n_total = 0;
    int n_fail  = 0;
    int lat;
    logic signed [15:0] re_v [8];
    logic signed [15:0] im_v [8];

    fft_peak_detect #(
        .N       (3),
        .W       (16),
        .SKIP_DC (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_bin    (in_bin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx),
        .res_pow   (res_pow),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_bins();
        for (int b = 0; b < 8; b++) begin
            re_v[b] = '0;
            im_v[b] = '0;
        end
    endtask

    task automatic send_frame(input int nbins, input bit bub);
        for (int b = 0; b < nbins; b++) begin
            if (bub) begin
                int g;
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_first = 1'b0;
                end
            end
            @(negedge clk);
            in_valid  = 1'b1;
            in_first  = (b == 0);
            in_bin[1] = re_v[b];
            in_bin[0] = im_v[b];
        end
    endtask

    task automatic wait_res(output int l);
        l = 0;
        for (int k = 1; k <= 12 && l == 0; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
            if (res_valid) l = k;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk(tag, res_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_bin    = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_idx", res_idx, 3'd0);
        chk("rst_pow", res_pow, 32'd0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // single peak at bin 2
        clear_bins();
        re_v[2] = 16'sd1000;
        send_frame(8, 1'b0);
        wait_res(lat);
        chk("peak_latency", lat, 3);
        chk("peak_idx", res_idx, 3'd2);
        chk("peak_pow", res_pow, 32'd1000000);
        consume("peak_consume");

        // tie keeps lowest index; bin 6 outside window
        clear_bins();
        im_v[1] = -16'sd300;
        im_v[3] = -16'sd300;
        re_v[6] = 16'sd5000;
        im_v[6] = 16'sd5000;
        send_frame(8, 1'b0);
        wait_res(lat);
        chk("tie_latency", lat, 3);
        chk("tie_idx", res_idx, 3'd1);
        chk("tie_pow", res_pow, 32'd90000);
        consume("tie_consume");

        // most negative inputs
        clear_bins();
        re_v[4] = -16'sd32768;
        im_v[4] = -16'sd32768;
        send_frame(8, 1'b0);
        wait_res(lat);
        chk("ext_idx", res_idx, 3'd4);
        chk("ext_pow", res_pow, 32'h8000_0000);
        consume("ext_consume");

        // DC excluded from search
        clear_bins();
        re_v[0] = 16'sd30000;
        im_v[0] = 16'sd30000;
        re_v[3] = 16'sd10;
        send_frame(8, 1'b0);
        wait_res(lat);
        chk("dc_idx", res_idx, 3'd3);
        chk("dc_pow", res_pow, 32'd100);
        consume("dc_consume");

        // new result loads in the same cycle as a handshake: no overrun
        clear_bins();
        im_v[4] = 16'sd10;
        send_frame(8, 1'b0);
        wait_res(lat);
        chk("sim_a_idx", res_idx, 3'd4);
        chk("sim_a_pow", res_pow, 32'd100);
        clear_bins();
        im_v[1] = 16'sd20;
        send_frame(8, 1'b0);
        idle(1);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("sim_valid", res_valid, 1'b1);
        chk("sim_idx", res_idx, 3'd1);
        chk("sim_pow", res_pow, 32'd400);
        chk("sim_overrun", overrun, 1'b0);
        consume("sim_consume");

        // two back-to-back frames with res_ready low: overwrite
        clear_bins();
        re_v[3] = 16'sd2;
        send_frame(8, 1'b0);
        clear_bins();
        re_v[2] = 16'sd200;
        send_frame(8, 1'b0);
        idle(3);
        chk("ovr_valid", res_valid, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_idx", res_idx, 3'd2);
        chk("ovr_pow", res_pow, 32'd40000);
        consume("ovr_consume");

        // in_first at bin 5 restarts the frame
        clear_bins();
        re_v[2] = 16'sd30000;
        send_frame(5, 1'b0);
        clear_bins();
        re_v[3] = 16'sd7;
        send_frame(8, 1'b0);
        wait_res(lat);
        chk("ferr_flag", frame_err, 1'b1);
        chk("ferr_latency", lat, 3);
        chk("ferr_idx", res_idx, 3'd3);
        chk("ferr_pow", res_pow, 32'd49);
        consume("ferr_consume");
        idle(12);
        chk("ferr_no_extra", res_valid, 1'b0);

        // bubbles within a frame
        clear_bins();
        re_v[4] = -16'sd5;
        im_v[4] = 16'sd12;
        re_v[7] = 16'sd9000;
        send_frame(8, 1'b1);
        wait_res(lat);
        chk("bub_latency", lat, 3);
        chk("bub_idx", res_idx, 3'd4);
        chk("bub_pow", res_pow, 32'd169);
        consume("bub_consume");

        // reset mid-frame
        clear_bins();
        re_v[1] = 16'sd9999;
        send_frame(4, 1'b0);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        #1;
        chk("mrst_valid", res_valid, 1'b0);
        chk("mrst_overrun", overrun, 1'b0);
        chk("mrst_frame_err", frame_err, 1'b0);
        chk("mrst_idx", res_idx, 3'd0);
        chk("mrst_pow", res_pow, 32'd0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid  = 1'b1;
        in_first  = 1'b0;
        in_bin[1] = 16'sd3000;
        in_bin[0] = 16'sd0;
        idle(8);
        chk("mrst_no_result", res_valid, 1'b0);
        clear_bins();
        re_v[2] = 16'sd3;
        im_v[2] = 16'sd4;
        send_frame(8, 1'b1);
        wait_res(lat);
        chk("post_latency", lat, 3);
        chk("post_idx", res_idx, 3'd2);
        chk("post_pow", res_pow, 32'd25);
        chk("post_overrun", overrun, 1'b0);
        consume("post_consume");

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
